eth_rx_frame_fifo: RTL
======================

// Module: eth_rx_frame_fifo
// PURPOSE
//  Store-and-forward RX frame buffer between the 10G MAC receive AXI-Stream (no backpressure) and the
//  NetTLP packet parser. Buffers each frame in full and forwards only frames the MAC marks good
//  (tuser=1 on tlast). Frames marked bad, or frames that overflow the buffer, are discarded whole.
//  Gives the parser a backpressurable (tready) stream.
// PARAMETERS
//  DEPTH_LOG2   9   buffer depth = 2**DEPTH_LOG2 beats of 64 bits (default 512 beats = 4 KiB)
// PORTS
//  eth_clk              in   1   MAC core clock (coreclk_out); all logic on rising edge
//  sys_rst              in   1   synchronous, active-high reset
//  s_axis_tvalid        in   1   MAC RX beat valid; no tready, so every valid beat must be taken
//  s_axis_tdata         in   64  MAC RX data, byte 0 in [7:0]
//  s_axis_tkeep         in   8   byte enables; 8'hFF on every non-last beat
//  s_axis_tlast         in   1   last beat of frame
//  s_axis_tuser         in   1   sampled only with tlast: 1=good frame, 0=bad (FCS/len error)
//  m_axis_tvalid        out  1   output beat valid
//  m_axis_tready        in   1   parser ready
//  m_axis_tdata         out  64  output data
//  m_axis_tkeep         out  8   output byte enables
//  m_axis_tlast         out  1   output last beat
//  drop_bad_cnt         out  32  frames dropped for tuser=0 (ETH_RX_FIFO_STATS_EN only)
//  drop_ovf_cnt         out  32  frames dropped for overflow (ETH_RX_FIFO_STATS_EN only)
//  good_frame_cnt       out  32  frames committed (ETH_RX_FIFO_STATS_EN only)
// BEHAVIOUR
//  - Storage: RAM of 73-bit entries {tlast,tkeep,tdata}. Pointers wr_ptr, commit_ptr, rd_ptr are each
//    DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1). full when wr_ptr-rd_ptr == 2**DEPTH_LOG2.
//  - Write FSM states: IDLE, RECV, DROP.
//    IDLE: a valid beat that is not full is written at wr_ptr and wr_ptr++. If tlast also set, handle
//          the beat as end-of-frame (below). Otherwise go to RECV.
//          A valid beat arriving while full goes to DROP (or stays in IDLE if tlast), ovf++.
//    RECV: each valid beat is written and wr_ptr++. A valid beat while full: wr_ptr<=commit_ptr,
//          go to DROP, ovf++. A full tlast beat: rollback, ovf++, go to IDLE.
//    DROP: valid beats are ignored. On tlast go to IDLE. tuser is ignored, and the frame counts only once.
//    End-of-frame (tlast written): if tuser=1, commit_ptr <= wr_ptr+1 (the frame is visible to the read
//    side next cycle) and good++. If tuser=0, wr_ptr <= commit_ptr and bad++.
//  - A frame longer than 2**DEPTH_LOG2 beats is always dropped as an overflow, and the FIFO does not
//    lock up.
//  - Read side: a committed word exists when rd_ptr != commit_ptr. Registered RAM read feeds a 1-entry
//    output register.
//    m_axis_* stays stable while tvalid=1 and tready=0. A transfer happens when tvalid & tready.
//    Back-to-back transfers run at 1 beat/cycle when tready is held high. Frames are output in arrival
//    order, and beats inside a frame are never reordered or split.
//  - Latency: tlast beat accepted in cycle T into an otherwise empty FIFO ->
//    m_axis_tvalid=1 with the first beat in cycle T+3.
//  - Read and write in the same cycle are both allowed. Full is computed from rd_ptr as it was before
//    the current cycle's read.
//  - Reset: all pointers 0, FSM=IDLE, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, counters=0.
//    Any partial or committed content is lost. The first valid beat after reset deasserts starts a new
//    frame, even if it is mid-frame on the wire.
//  - Counters saturate at 32'hFFFF_FFFF.
// CONFIGURATION
//  ETH_RX_FIFO_STATS_EN defined: the three counters are implemented as above.
//  Not defined: drop_bad_cnt, drop_ovf_cnt and good_frame_cnt are tied to 32'd0, and no counter logic
//  is built. Data path behaviour is the same in both builds.
// TESTING
//  1. 8-beat good frame (tuser=1), tready=1 -> the same 8 beats come out, first at T+3, last tkeep kept
//     (e.g. 8'h0F); good=1.
//  2. Good frame A, then bad frame B (tuser=0), then good frame C, back-to-back -> output is A then C
//     only; bad=1, good=2.
//  3. DEPTH_LOG2=4, 20-beat frame with tready=0 -> dropped, ovf=1. The next 4-beat good frame is output
//     complete.
//  4. Two 6-beat good frames with tready toggled 1010... -> every beat appears exactly once, in order,
//     and data stays stable while stalled.
//  5. sys_rst pulsed for 1 cycle in the middle of a frame, with one committed frame queued ->
//     m_axis_tvalid=0 the cycle after. The following good frame is output alone.
//  6. Build without ETH_RX_FIFO_STATS_EN and run scenario 2 -> same data output, all counters 0.

Source files
------------

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame buffer, MAC stream in, parser stream out; only good frames leave.
// Latency: tlast of a good frame accepted in cycle T -> first beat valid on m_axis in cycle T+3.
// Backpressure: none on s_axis (bad/overflowing frames dropped whole); m_axis holds steady while tvalid & !tready.
// Build option ETH_RX_FIFO_STATS_EN adds the drop/good frame counters; otherwise they read as zero.
module eth_rx_frame_fifo #(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic        eth_clk,
   input  logic        sys_rst,
   input  logic        s_axis_tvalid,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic [31:0] drop_bad_cnt,
   output logic [31:0] drop_ovf_cnt,
   output logic [31:0] good_frame_cnt
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};

   // One stored beat: {tlast, tkeep, tdata}
   typedef struct packed {
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } beat_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } wr_state_t;

   beat_t mem [0:(1 << DEPTH_LOG2) - 1];

   wr_state_t     st_q;
   wr_state_t     st_d;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr_d;
   logic [PW-1:0] wr_ptr_inc;
   logic [PW-1:0] commit_ptr;
   logic [PW-1:0] commit_ptr_d;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          wr_en;
   logic          bad_inc;
   logic          ovf_inc;
   logic          good_inc;
   beat_t         wr_beat;

   logic          rd_avail;
   logic          rd_en;
   logic          ram_vld;
   logic          pop_ram;
   beat_t         ram_q;
   beat_t         out_q;
   logic          out_vld;

   // Full uses rd_ptr from before this cycle's read, so a same-cycle read never frees space early.
   assign full       = (wr_ptr - rd_ptr) == DEPTH_W;
   assign wr_ptr_inc = wr_ptr + 1'b1;
   assign wr_beat    = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

   // Write FSM next state: accept beats, commit good frames, roll back bad or overflowing ones
   always_comb begin
      st_d         = st_q;
      wr_ptr_d     = wr_ptr;
      commit_ptr_d = commit_ptr;
      wr_en        = 1'b0;
      bad_inc      = 1'b0;
      ovf_inc      = 1'b0;
      good_inc     = 1'b0;
      case (st_q)
         ST_IDLE, ST_RECV: begin
            if (s_axis_tvalid) begin
               if (full) begin
                  // In IDLE wr_ptr already equals commit_ptr, so the rollback is harmless there.
                  wr_ptr_d = commit_ptr;
                  ovf_inc  = 1'b1;
                  st_d     = s_axis_tlast ? ST_IDLE : ST_DROP;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_inc;
                  if (s_axis_tlast) begin
                     st_d = ST_IDLE;
                     if (s_axis_tuser) begin
                        commit_ptr_d = wr_ptr_inc;
                        good_inc     = 1'b1;
                     end else begin
                        wr_ptr_d = commit_ptr;
                        bad_inc  = 1'b1;
                     end
                  end else begin
                     st_d = ST_RECV;
                  end
               end
            end
         end
         ST_DROP: begin
            // Rest of an overflowed frame is discarded; it was already counted once.
            if (s_axis_tvalid && s_axis_tlast) begin
               st_d = ST_IDLE;
            end
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   // Write FSM state and write-side pointers
   always_ff @(posedge eth_clk) begin
      if (sys_rst) begin
         st_q       <= ST_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
      end else begin
         st_q       <= st_d;
         wr_ptr     <= wr_ptr_d;
         commit_ptr <= commit_ptr_d;
      end
   end

   // RAM write port: one entry per accepted MAC beat
   always_ff @(posedge eth_clk) begin
      if (wr_en) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_beat;
      end
   end

   // Read pipeline: RAM output register (ram_q) feeds the output register (out_q).
   // A read is issued only when ram_q will be free next cycle, so ram_q doubles as the
   // skid slot that keeps 1 beat/cycle while m_axis_tready stays high.
   assign rd_avail = rd_ptr != commit_ptr;
   assign pop_ram  = ram_vld && (!out_vld || m_axis_tready);
   assign rd_en    = rd_avail && (!ram_vld || pop_ram);

   // RAM registered read port; reads only touch committed entries, never the write address
   always_ff @(posedge eth_clk) begin
      if (rd_en) begin
         ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
   end

   // Read pointer and RAM-output-valid flag
   always_ff @(posedge eth_clk) begin
      if (sys_rst) begin
         rd_ptr  <= '0;
         ram_vld <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (rd_en) begin
            ram_vld <= 1'b1;
         end else if (pop_ram) begin
            ram_vld <= 1'b0;
         end
      end
   end

   // Output register: load when empty or being consumed, hold while stalled
   always_ff @(posedge eth_clk) begin
      if (sys_rst) begin
         out_vld <= 1'b0;
         out_q   <= '0;
      end else if (pop_ram) begin
         out_vld <= 1'b1;
         out_q   <= ram_q;
      end else if (m_axis_tready) begin
         out_vld <= 1'b0;
      end
   end

   assign m_axis_tvalid = out_vld;
   assign m_axis_tdata  = out_q.data;
   assign m_axis_tkeep  = out_q.keep;
   assign m_axis_tlast  = out_q.last;

`ifdef ETH_RX_FIFO_STATS_EN
   logic [31:0] bad_cnt_q;
   logic [31:0] ovf_cnt_q;
   logic [31:0] good_cnt_q;

   // Saturating per-frame statistics
   always_ff @(posedge eth_clk) begin
      if (sys_rst) begin
         bad_cnt_q  <= '0;
         ovf_cnt_q  <= '0;
         good_cnt_q <= '0;
      end else begin
         if (bad_inc && (bad_cnt_q != 32'hFFFF_FFFF)) begin
            bad_cnt_q <= bad_cnt_q + 32'd1;
         end
         if (ovf_inc && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 32'd1;
         end
         if (good_inc && (good_cnt_q != 32'hFFFF_FFFF)) begin
            good_cnt_q <= good_cnt_q + 32'd1;
         end
      end
   end

   assign drop_bad_cnt   = bad_cnt_q;
   assign drop_ovf_cnt   = ovf_cnt_q;
   assign good_frame_cnt = good_cnt_q;
`else
   logic unused_stats;
   assign unused_stats   = ^{bad_inc, ovf_inc, good_inc};
   assign drop_bad_cnt   = 32'd0;
   assign drop_ovf_cnt   = 32'd0;
   assign good_frame_cnt = 32'd0;
`endif

endmodule
